// File: rtl/time_keeper.sv
// time_keeper: seconds/minutes/hours counter driven by a one-second tick.
// The tick is edge-detected so a tick level held for several mclk cycles
// counts once. A load request, legal or not, always takes priority over a tick
// in the same cycle. Every output comes straight from a flop.
module time_keeper #(
    parameter int HOUR_MODULUS = 24
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hr,
    output logic       load_ack,
    output logic       load_err,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       day_rco
);

    localparam logic [5:0] SM_MAX = 6'd59;
    localparam logic [4:0] HR_MAX = 5'(HOUR_MODULUS - 1);

    // Increment with wrap to zero at the given maximum (6-bit fields).
    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] vmax);
        return (v == vmax) ? 6'd0 : v + 6'd1;
    endfunction

    // Increment with wrap to zero at the given maximum (5-bit fields).
    function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] vmax);
        return (v == vmax) ? 5'd0 : v + 5'd1;
    endfunction

    logic       tick_q;
    logic       tick_ev;
    logic       load_ok;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic       day_wrap;
    logic [5:0] sec_nxt;
    logic [5:0] min_nxt;
    logic [4:0] hr_nxt;

    assign tick_ev = tick_in & ~tick_q;

    // Range check of the requested load value against the clock's limits.
    always_comb begin
        load_ok = (load_sec <= SM_MAX) && (load_min <= SM_MAX) && (load_hr <= HR_MAX);
    end

    // Time one second from now, with carries rippling sec -> min -> hr.
    always_comb begin
        sec_wrap = (sec == SM_MAX);
        min_wrap = (min == SM_MAX);
        hr_wrap  = (hr == HR_MAX);
        day_wrap = sec_wrap & min_wrap & hr_wrap;
        sec_nxt  = wrap_inc6(sec, SM_MAX);
        min_nxt  = min;
        hr_nxt   = hr;
        if (sec_wrap) begin
            min_nxt = wrap_inc6(min, SM_MAX);
            if (min_wrap) begin
                hr_nxt = wrap_inc5(hr, HR_MAX);
            end
        end
    end

    // Time registers, tick edge detector and the one-cycle status pulses.
    always_ff @(posedge mclk) begin
        if (reset) begin
            // tick_q preset high: a tick level present at release is not a new edge.
            tick_q   <= 1'b1;
            sec      <= 6'd0;
            min      <= 6'd0;
            hr       <= 5'd0;
            load_ack <= 1'b0;
            load_err <= 1'b0;
            day_rco  <= 1'b0;
        end else begin
            tick_q   <= tick_in;
            load_ack <= 1'b0;
            load_err <= 1'b0;
            day_rco  <= 1'b0;
            if (load) begin
                // A same-cycle tick is dropped here whether or not the load is legal.
                if (load_ok) begin
                    sec      <= load_sec;
                    min      <= load_min;
                    hr       <= load_hr;
                    load_ack <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_ev && run) begin
                sec     <= sec_nxt;
                min     <= min_nxt;
                hr      <= hr_nxt;
                day_rco <= day_wrap;
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a 24-hour and a 12-hour instance share one stimulus
// stream. Each is compared every cycle against a model that keeps time as a
// plain count of seconds into the day; a vector table and a few directed
// sequences add hand-computed expectations.
module tb_time_keeper;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_sec = '0;
    logic [5:0] load_min = '0;
    logic [4:0] load_hr = '0;

    logic       ack24, err24, rco24, ack12, err12, rco12;
    logic [5:0] sec24, min24, sec12, min12;
    logic [4:0] hr24, hr12;

    int n_tests = 0;
    int n_fail = 0;

    always #5 mclk = ~mclk;

    time_keeper #(.HOUR_MODULUS(24)) dut24 (
        .mclk(mclk), .reset(reset), .tick_in(tick_in), .run(run), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .load_ack(ack24), .load_err(err24), .sec(sec24), .min(min24), .hr(hr24),
        .day_rco(rco24)
    );

    time_keeper #(.HOUR_MODULUS(12)) dut12 (
        .mclk(mclk), .reset(reset), .tick_in(tick_in), .run(run), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .load_ack(ack12), .load_err(err12), .sec(sec12), .min(min12), .hr(hr12),
        .day_rco(rco12)
    );

    // Reference model state: [0] = 24-hour clock, [1] = 12-hour clock.
    int hm_c[2] = '{24, 12};
    int t_m[2];
    bit prev_m[2];
    bit ack_m[2], err_m[2], rco_m[2];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply the rules to the inputs seen at this clock edge.
    task automatic model_update();
        bit ev;
        for (int k = 0; k < 2; k++) begin
            ack_m[k] = 1'b0;
            err_m[k] = 1'b0;
            rco_m[k] = 1'b0;
            if (reset) begin
                t_m[k]    = 0;
                prev_m[k] = 1'b1;
            end else begin
                ev        = tick_in && !prev_m[k];
                prev_m[k] = tick_in;
                if (load) begin
                    if (load_sec <= 59 && load_min <= 59 && int'(load_hr) < hm_c[k]) begin
                        t_m[k]   = int'(load_hr) * 3600 + int'(load_min) * 60 + int'(load_sec);
                        ack_m[k] = 1'b1;
                    end else begin
                        err_m[k] = 1'b1;
                    end
                end else if (ev && run) begin
                    t_m[k]   = (t_m[k] + 1) % (hm_c[k] * 3600);
                    rco_m[k] = (t_m[k] == 0);
                end
            end
        end
    endtask

    task automatic chk_models();
        chk("sec24", sec24, t_m[0] % 60);
        chk("min24", min24, (t_m[0] / 60) % 60);
        chk("hr24", hr24, t_m[0] / 3600);
        chk("ack24", ack24, ack_m[0]);
        chk("err24", err24, err_m[0]);
        chk("rco24", rco24, rco_m[0]);
        chk("sec12", sec12, t_m[1] % 60);
        chk("min12", min12, (t_m[1] / 60) % 60);
        chk("hr12", hr12, t_m[1] / 3600);
        chk("ack12", ack12, ack_m[1]);
        chk("err12", err12, err_m[1]);
        chk("rco12", rco12, rco_m[1]);
        chk("excl24", (int'(ack24) + int'(err24) + int'(rco24)) <= 1, 1);
        chk("excl12", (int'(ack12) + int'(err12) + int'(rco12)) <= 1, 1);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge mclk);
        model_update();
        #1;
        chk_models();
    endtask

    task automatic set_in(input bit r, input bit ld, input bit tk, input bit rn,
                          input int h, input int m, input int s);
        reset    = r;
        load     = ld;
        tick_in  = tk;
        run      = rn;
        load_hr  = 5'(h);
        load_min = 6'(m);
        load_sec = 6'(s);
    endtask

    typedef struct {
        bit rst, ld, tk, rn;
        int lh, lm, ls;
        int eh, em, es;
        bit ea, ee, er;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ld, bit tk, bit rn, int lh, int lm, int ls,
                                int eh, int em, int es, bit ea, bit ee, bit er);
        vec_t v;
        v.rst = rst; v.ld = ld; v.tk = tk; v.rn = rn;
        v.lh = lh; v.lm = lm; v.ls = ls;
        v.eh = eh; v.em = em; v.es = es;
        v.ea = ea; v.ee = ee; v.er = er;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        // Expected values are for the 24-hour instance.
        //         rst ld tk rn  lh lm ls   eh em es  ack err rco
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 23,59,58,  23,59,58,  1, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,  23,59,59,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1,  0, 0, 0,  23,59,59,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 0,  0, 0, 1));
        vt.push_back(mk(0, 0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 10,60, 0,   0, 0, 0,  0, 1, 0));
        vt.push_back(mk(0, 1, 0, 1, 24, 0, 0,   0, 0, 0,  0, 1, 0));
        vt.push_back(mk(0, 1, 1, 1,  5, 6, 7,   5, 6, 7,  1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 0,   5, 6, 7,  0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,  0, 0, 0,   0, 0, 0,  1, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 12,34,56,  12,34,56,  1, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 12,34,56,  12,34,56,  1, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,  12,34,57,  0, 0, 0));
        vt.push_back(mk(1, 1, 1, 1,  1, 2, 3,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,  0, 0, 0,   0, 0, 1,  0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].rst, vt[i].ld, vt[i].tk, vt[i].rn, vt[i].lh, vt[i].lm, vt[i].ls);
            step();
            chk($sformatf("vec%0d_hr", i), hr24, vt[i].eh);
            chk($sformatf("vec%0d_min", i), min24, vt[i].em);
            chk($sformatf("vec%0d_sec", i), sec24, vt[i].es);
            chk($sformatf("vec%0d_ack", i), ack24, vt[i].ea);
            chk($sformatf("vec%0d_err", i), err24, vt[i].ee);
            chk($sformatf("vec%0d_rco", i), rco24, vt[i].er);
        end

        // 60 single-cycle ticks from reset: seconds roll over into minute 1.
        set_in(1, 0, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        for (int i = 1; i <= 60; i++) begin
            tick_in = 1'b1;
            step();
            chk("count60_sec", sec24, i % 60);
            tick_in = 1'b0;
            step();
        end
        chk("count60_min", min24, 1);
        chk("count60_hr", hr24, 0);

        // 12-hour wrap: 11:59:59 plus one tick.
        set_in(0, 1, 0, 1, 11, 59, 59);
        step();
        chk("ld12_ack", ack12, 1);
        set_in(0, 0, 1, 1, 0, 0, 0);
        step();
        chk("wrap12_hr", hr12, 0);
        chk("wrap12_min", min12, 0);
        chk("wrap12_sec", sec12, 0);
        chk("wrap12_rco", rco12, 1);
        chk("wrap24_hr", hr24, 12);
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        chk("wrap12_rco_off", rco12, 0);

        // Load held for three cycles: one ack per cycle; then an illegal hold.
        set_in(0, 1, 0, 1, 3, 4, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_ack", ack24, 1);
        end
        set_in(0, 1, 0, 1, 3, 61, 5);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_err", err24, 1);
            chk("hold_min", min24, 4);
        end
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        chk("hold_end_ack", ack24, 0);

        // Randomized traffic, checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            run     = ($urandom_range(0, 7) != 0);
            tick_in = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
            load    = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) begin
                load_hr  = 5'($urandom);
                load_min = 6'($urandom);
                load_sec = 6'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                load_hr  = 5'($urandom_range(0, 1) ? 23 : 11);
                load_min = 6'd59;
                load_sec = 6'($urandom_range(55, 59));
            end else begin
                load_hr  = 5'($urandom_range(0, 23));
                load_min = 6'($urandom_range(0, 59));
                load_sec = 6'($urandom_range(0, 59));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
